// File: rtl/dm_sba_if.sv
// System-bus side of the debug-module SBA engine: one 32-bit word request at a time,
// held until acknowledged. master = SBA engine, slave = interconnect / memory.
interface dm_sba_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic        bus_err;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_err, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_err, bus_rdata
  );
endinterface

// File: rtl/dm_sba.sv
// Debug-module System Bus Access engine. Owns sbcs (0x38), sbaddress0 (0x39) and
// sbdata0 (0x3C) and masters single 32-bit word accesses on the system bus.
// Optional feature macro: DM_SBA_TIMEOUT_EN -- when defined, a request that is not
// acknowledged within TIMEOUT_CYCLES cycles is abandoned with sberror=1.
module dm_sba
`ifdef DM_SBA_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
)
`endif
(
  input  logic         clk_i,
  input  logic         rst_ni,      // synchronous, active low
  input  logic         dmi_wr_i,
  input  logic         dmi_rd_i,
  input  logic [6:0]   dmi_addr_i,
  input  logic [31:0]  dmi_wdata_i,
  output logic [31:0]  dmi_rdata_o,
  dm_sba_if.master     bus
);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e      state_q, state_d;
  logic        busy;

  logic        sbreadonaddr_q, sbreadonaddr_d;
  logic [2:0]  sbaccess_q, sbaccess_d;
  logic        sbautoinc_q, sbautoinc_d;
  logic        sbreadondata_q, sbreadondata_d;
  logic [2:0]  sberror_q, sberror_d;
  logic        sbbusyerror_q, sbbusyerror_d;
  logic [31:0] sbaddress_q, sbaddress_d;
  logic [31:0] sbdata_q, sbdata_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;

  logic        wr_sbcs, wr_addr, wr_data, rd_data;
  logic        gate_ok;
  logic        start, start_we, launch;
  logic [31:0] start_addr;
  logic [2:0]  start_err;
  logic        done;
  logic        timeout;

  assign wr_sbcs = dmi_wr_i && (dmi_addr_i == 7'h38);
  assign wr_addr = dmi_wr_i && (dmi_addr_i == 7'h39);
  assign wr_data = dmi_wr_i && (dmi_addr_i == 7'h3C);
  assign rd_data = dmi_rd_i && (dmi_addr_i == 7'h3C);
  // Any latched error blocks new accesses until the debugger clears it.
  assign gate_ok = (sberror_q == 3'd0) && !sbbusyerror_q;
  assign done    = (state_q == StReq) && bus.bus_ack;

`ifdef DM_SBA_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;

  assign timeout = (state_q == StReq) && !bus.bus_ack &&
                   (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Count cycles spent in REQ; idle keeps the counter cleared for the next access.
  always_comb begin
    cnt_d = '0;
    if (state_q == StReq) cnt_d = cnt_q + 1'b1;
  end

  // Timeout counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // Decode start requests and run the access checks on the address that will be used.
  always_comb begin
    start      = 1'b0;
    start_we   = 1'b0;
    start_addr = sbaddress_q;
    if (!busy && gate_ok) begin
      if (wr_data) begin
        start    = 1'b1;
        start_we = 1'b1;
      end else if (wr_addr) begin
        start_addr = dmi_wdata_i;
        start      = sbreadonaddr_q;
      end else if (rd_data) begin
        start = sbreadondata_q;
      end
    end
    start_err = 3'd0;
    if (start) begin
      if (sbaccess_q != 3'd2)           start_err = 3'd4;
      else if (start_addr[1:0] != 2'b0) start_err = 3'd3;
    end
    launch = start && (start_err == 3'd0);
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (launch) state_d = StReq;
      StReq:   if (bus.bus_ack || timeout) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy        = (state_q == StReq);
    bus.bus_req = (state_q == StReq);
  end

  // Register file next state; new errors are applied last so they beat a W1C clear.
  always_comb begin
    sbreadonaddr_d = sbreadonaddr_q;
    sbaccess_d     = sbaccess_q;
    sbautoinc_d    = sbautoinc_q;
    sbreadondata_d = sbreadondata_q;
    sberror_d      = sberror_q;
    sbbusyerror_d  = sbbusyerror_q;
    sbaddress_d    = sbaddress_q;
    sbdata_d       = sbdata_q;
    bus_we_d       = bus_we_q;
    bus_addr_d     = bus_addr_q;
    bus_wdata_d    = bus_wdata_q;

    if (wr_sbcs) begin
      sbreadonaddr_d = dmi_wdata_i[20];
      sbaccess_d     = dmi_wdata_i[19:17];
      sbautoinc_d    = dmi_wdata_i[16];
      sbreadondata_d = dmi_wdata_i[15];
      sberror_d      = sberror_q & ~dmi_wdata_i[14:12];
      sbbusyerror_d  = sbbusyerror_q & ~dmi_wdata_i[22];
    end

    if (busy && (wr_addr || wr_data || rd_data)) sbbusyerror_d = 1'b1;
    if (!busy && wr_addr) sbaddress_d = dmi_wdata_i;
    if (!busy && wr_data) sbdata_d    = dmi_wdata_i;

    if (start_err != 3'd0) sberror_d = start_err;

    if (launch) begin
      bus_we_d    = start_we;
      bus_addr_d  = start_addr;
      bus_wdata_d = start_we ? dmi_wdata_i : sbdata_q;
    end

    if (done) begin
      if (bus.bus_err) begin
        sberror_d = 3'd2;
      end else begin
        if (!bus_we_q) sbdata_d = bus.bus_rdata;
        if (sbautoinc_q) sbaddress_d = sbaddress_q + 32'd4;
      end
    end

    if (timeout) sberror_d = 3'd1;
  end

  // Register file and bus launch registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sbreadonaddr_q <= 1'b0;
      sbaccess_q     <= 3'd0;
      sbautoinc_q    <= 1'b0;
      sbreadondata_q <= 1'b0;
      sberror_q      <= 3'd0;
      sbbusyerror_q  <= 1'b0;
      sbaddress_q    <= 32'd0;
      sbdata_q       <= 32'd0;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= 32'd0;
      bus_wdata_q    <= 32'd0;
    end else begin
      sbreadonaddr_q <= sbreadonaddr_d;
      sbaccess_q     <= sbaccess_d;
      sbautoinc_q    <= sbautoinc_d;
      sbreadondata_q <= sbreadondata_d;
      sberror_q      <= sberror_d;
      sbbusyerror_q  <= sbbusyerror_d;
      sbaddress_q    <= sbaddress_d;
      sbdata_q       <= sbdata_d;
      bus_we_q       <= bus_we_d;
      bus_addr_q     <= bus_addr_d;
      bus_wdata_q    <= bus_wdata_d;
    end
  end

  // Bus outputs and combinational DMI read mux.
  always_comb begin
    bus.bus_we    = bus_we_q;
    bus.bus_addr  = {bus_addr_q[31:2], 2'b00};
    bus.bus_wdata = bus_wdata_q;
    unique case (dmi_addr_i)
      // sbversion=1, sbasize=32, only 32-bit accesses supported
      7'h38:   dmi_rdata_o = {3'd1, 6'd0, sbbusyerror_q, busy, sbreadonaddr_q, sbaccess_q,
                              sbautoinc_q, sbreadondata_q, sberror_q, 7'd32, 5'b00100};
      7'h39:   dmi_rdata_o = sbaddress_q;
      7'h3C:   dmi_rdata_o = sbdata_q;
      default: dmi_rdata_o = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_dm_sba.sv
// Directed bench for dm_sba: DMI register programming, bus write/read, auto-increment,
// read-on-data, alignment/size errors, busy violations, bus errors and reset mid-access.
module tb_dm_sba;
  logic        clk;
  logic        rst_n;
  logic        dmi_wr;
  logic        dmi_rd;
  logic [6:0]  dmi_addr;
  logic [31:0] dmi_wdata;
  logic [31:0] dmi_rdata;

  dm_sba_if bus ();

`ifdef DM_SBA_TIMEOUT_EN
  dm_sba #(.TIMEOUT_CYCLES(8)) dut (
`else
  dm_sba dut (
`endif
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .dmi_wr_i    (dmi_wr),
    .dmi_rd_i    (dmi_rd),
    .dmi_addr_i  (dmi_addr),
    .dmi_wdata_i (dmi_wdata),
    .dmi_rdata_o (dmi_rdata),
    .bus         (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int starts = 0;
  int beats = 0;
  logic req_prev = 1'b0;
  logic [31:0] v;
  int snap;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count request launches and completed beats.
  always @(posedge clk) begin
    if (bus.bus_req && !req_prev) starts <= starts + 1;
    if (bus.bus_req && bus.bus_ack) beats <= beats + 1;
    req_prev <= bus.bus_req;
  end

  task automatic dmi_write(input logic [6:0] a, input logic [31:0] d);
    @(negedge clk);
    dmi_wr = 1'b1; dmi_addr = a; dmi_wdata = d;
    @(negedge clk);
    dmi_wr = 1'b0;
  endtask

  task automatic dmi_read(input logic [6:0] a, output logic [31:0] d);
    @(negedge clk);
    dmi_rd = 1'b1; dmi_addr = a;
    #1 d = dmi_rdata;
    @(negedge clk);
    dmi_rd = 1'b0;
  endtask

  task automatic peek(input logic [6:0] a, output logic [31:0] d);
    dmi_addr = a;
    #1 d = dmi_rdata;
  endtask

  task automatic respond(input int dly, input logic err, input logic [31:0] rd);
    repeat (dly) @(negedge clk);
    bus.bus_ack = 1'b1; bus.bus_err = err; bus.bus_rdata = rd;
    @(negedge clk);
    bus.bus_ack = 1'b0; bus.bus_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_chk++; if (bus.bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", bus.bus_req); end
    n_chk++; if (bus.bus_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0b want 0", bus.bus_we); end
    n_chk++; if (bus.bus_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.bus_addr); end
    n_chk++; if (bus.bus_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", bus.bus_wdata); end
    peek(7'h38, v);
    n_chk++; if (v !== 32'h2000_0404) begin n_fail++; $display("FAIL reset_sbcs: got %h want 20000404", v); end
    peek(7'h39, v);
    n_chk++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_sbaddress: got %h want 0", v); end
    peek(7'h3C, v);
    n_chk++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_sbdata: got %h want 0", v); end
    peek(7'h10, v);
    n_chk++; if (v !== 32'h0) begin n_fail++; $display("FAIL other_addr_read: got %h want 0", v); end
  endtask

  task automatic test_write();
    dmi_write(7'h38, 32'h0004_0000);
    dmi_write(7'h39, 32'h0000_1000);
    n_chk++; if (bus.bus_req !== 1'b0) begin n_fail++; $display("FAIL addr_no_start: got %0b want 0", bus.bus_req); end
    dmi_write(7'h3C, 32'hDEAD_BEEF);
    n_chk++; if (bus.bus_req !== 1'b1) begin n_fail++; $display("FAIL wr_req: got %0b want 1", bus.bus_req); end
    n_chk++; if (bus.bus_we !== 1'b1) begin n_fail++; $display("FAIL wr_we: got %0b want 1", bus.bus_we); end
    n_chk++; if (bus.bus_addr !== 32'h1000) begin n_fail++; $display("FAIL wr_addr: got %h want 1000", bus.bus_addr); end
    n_chk++; if (bus.bus_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_wdata: got %h want deadbeef", bus.bus_wdata); end
    peek(7'h38, v);
    n_chk++; if (v[21] !== 1'b1) begin n_fail++; $display("FAIL wr_busy: got %0b want 1", v[21]); end
    snap = beats;
    respond(3, 1'b0, 32'h0);
    n_chk++; if (bus.bus_req !== 1'b0) begin n_fail++; $display("FAIL wr_req_drop: got %0b want 0", bus.bus_req); end
    n_chk++; if (beats !== snap + 1) begin n_fail++; $display("FAIL wr_beats: got %0d want %0d", beats, snap + 1); end
    peek(7'h38, v);
    n_chk++; if (v[21] !== 1'b0) begin n_fail++; $display("FAIL wr_busy_clear: got %0b want 0", v[21]); end
    n_chk++; if (v[14:12] !== 3'd0) begin n_fail++; $display("FAIL wr_sberror: got %0d want 0", v[14:12]); end
    peek(7'h39, v);
    n_chk++; if (v !== 32'h1000) begin n_fail++; $display("FAIL wr_no_autoinc: got %h want 1000", v); end
  endtask

  task automatic test_read_on_addr();
    dmi_write(7'h38, 32'h0015_0000);
    dmi_write(7'h39, 32'h0000_2000);
    n_chk++; if (bus.bus_req !== 1'b1) begin n_fail++; $display("FAIL roa_req: got %0b want 1", bus.bus_req); end
    n_chk++; if (bus.bus_we !== 1'b0) begin n_fail++; $display("FAIL roa_we: got %0b want 0", bus.bus_we); end
    n_chk++; if (bus.bus_addr !== 32'h2000) begin n_fail++; $display("FAIL roa_addr: got %h want 2000", bus.bus_addr); end
    respond(1, 1'b0, 32'h1234_5678);
    peek(7'h3C, v);
    n_chk++; if (v !== 32'h1234_5678) begin n_fail++; $display("FAIL roa_sbdata: got %h want 12345678", v); end
    peek(7'h39, v);
    n_chk++; if (v !== 32'h2004) begin n_fail++; $display("FAIL roa_autoinc: got %h want 2004", v); end
  endtask

  task automatic test_read_on_data();
    dmi_write(7'h38, 32'h0005_8000);
    dmi_read(7'h3C, v);
    n_chk++; if (v !== 32'h1234_5678) begin n_fail++; $display("FAIL rod_first_data: got %h want 12345678", v); end
    n_chk++; if (bus.bus_addr !== 32'h2004) begin n_fail++; $display("FAIL rod_first_addr: got %h want 2004", bus.bus_addr); end
    n_chk++; if (bus.bus_req !== 1'b1) begin n_fail++; $display("FAIL rod_first_req: got %0b want 1", bus.bus_req); end
    respond(0, 1'b0, 32'hAAAA_0001);
    dmi_read(7'h3C, v);
    n_chk++; if (v !== 32'hAAAA_0001) begin n_fail++; $display("FAIL rod_second_data: got %h want aaaa0001", v); end
    n_chk++; if (bus.bus_addr !== 32'h2008) begin n_fail++; $display("FAIL rod_second_addr: got %h want 2008", bus.bus_addr); end
    respond(0, 1'b0, 32'hBBBB_0002);
    peek(7'h3C, v);
    n_chk++; if (v !== 32'hBBBB_0002) begin n_fail++; $display("FAIL rod_sbdata: got %h want bbbb0002", v); end
    peek(7'h39, v);
    n_chk++; if (v !== 32'h200C) begin n_fail++; $display("FAIL rod_sbaddress: got %h want 200c", v); end
  endtask

  task automatic test_start_checks();
    dmi_write(7'h38, 32'h0014_0000);
    snap = starts;
    dmi_write(7'h39, 32'h0000_3002);
    n_chk++; if (bus.bus_req !== 1'b0) begin n_fail++; $display("FAIL misalign_req: got %0b want 0", bus.bus_req); end
    peek(7'h38, v);
    n_chk++; if (v[14:12] !== 3'd3) begin n_fail++; $display("FAIL misalign_sberror: got %0d want 3", v[14:12]); end
    dmi_write(7'h38, 32'h0014_7000);
    peek(7'h38, v);
    n_chk++; if (v[14:12] !== 3'd0) begin n_fail++; $display("FAIL w1c_sberror: got %0d want 0", v[14:12]); end
    dmi_write(7'h38, 32'h0010_0000);
    dmi_write(7'h39, 32'h0000_4000);
    peek(7'h38, v);
    n_chk++; if (v[14:12] !== 3'd4) begin n_fail++; $display("FAIL size_sberror: got %0d want 4", v[14:12]); end
    n_chk++; if (starts !== snap) begin n_fail++; $display("FAIL check_no_bus: got %0d starts want %0d", starts, snap); end
    dmi_write(7'h38, 32'h0004_7000);
  endtask

  task automatic test_busy();
    dmi_write(7'h39, 32'h0000_5000);
    dmi_write(7'h3C, 32'h1111_1111);
    dmi_write(7'h3C, 32'h2222_2222);
    peek(7'h38, v);
    n_chk++; if (v[22] !== 1'b1) begin n_fail++; $display("FAIL busyerr_set: got %0b want 1", v[22]); end
    peek(7'h3C, v);
    n_chk++; if (v !== 32'h1111_1111) begin n_fail++; $display("FAIL busy_sbdata_kept: got %h want 11111111", v); end
    n_chk++; if (bus.bus_wdata !== 32'h1111_1111) begin n_fail++; $display("FAIL busy_wdata_stable: got %h want 11111111", bus.bus_wdata); end
    respond(0, 1'b0, 32'h0);
    snap = starts;
    dmi_write(7'h3C, 32'h3333_3333);
    n_chk++; if (bus.bus_req !== 1'b0) begin n_fail++; $display("FAIL busyerr_gate: got %0b want 0", bus.bus_req); end
    dmi_write(7'h38, 32'h0044_0000);
    peek(7'h38, v);
    n_chk++; if (v[22] !== 1'b0) begin n_fail++; $display("FAIL busyerr_w1c: got %0b want 0", v[22]); end
    n_chk++; if (starts !== snap) begin n_fail++; $display("FAIL busyerr_no_start: got %0d want %0d", starts, snap); end
    dmi_write(7'h3C, 32'h4444_4444);
    n_chk++; if (bus.bus_wdata !== 32'h4444_4444) begin n_fail++; $display("FAIL busy_restart_wdata: got %h want 44444444", bus.bus_wdata); end
    // DMI write coinciding with the ack still counts as a busy violation
    @(negedge clk);
    bus.bus_ack = 1'b1; dmi_wr = 1'b1; dmi_addr = 7'h3C; dmi_wdata = 32'h6666_6666;
    @(negedge clk);
    bus.bus_ack = 1'b0; dmi_wr = 1'b0;
    peek(7'h38, v);
    n_chk++; if (v[22] !== 1'b1) begin n_fail++; $display("FAIL ack_collide_busyerr: got %0b want 1", v[22]); end
    peek(7'h3C, v);
    n_chk++; if (v !== 32'h4444_4444) begin n_fail++; $display("FAIL ack_collide_sbdata: got %h want 44444444", v); end
    dmi_write(7'h38, 32'h0044_0000);
  endtask

  task automatic test_bus_err();
    dmi_write(7'h38, 32'h0005_0000);
    dmi_write(7'h3C, 32'h7777_7777);
    respond(2, 1'b1, 32'h0);
    peek(7'h38, v);
    n_chk++; if (v[14:12] !== 3'd2) begin n_fail++; $display("FAIL buserr_sberror: got %0d want 2", v[14:12]); end
    peek(7'h39, v);
    n_chk++; if (v !== 32'h5000) begin n_fail++; $display("FAIL buserr_no_autoinc: got %h want 5000", v); end
    dmi_write(7'h38, 32'h0005_7000);
    dmi_write(7'h3C, 32'h8888_8888);
    // W1C and a new bus error in the same cycle
    @(negedge clk);
    bus.bus_ack = 1'b1; bus.bus_err = 1'b1;
    dmi_wr = 1'b1; dmi_addr = 7'h38; dmi_wdata = 32'h0005_7000;
    @(negedge clk);
    bus.bus_ack = 1'b0; bus.bus_err = 1'b0; dmi_wr = 1'b0;
    peek(7'h38, v);
    n_chk++; if (v[14:12] !== 3'd2) begin n_fail++; $display("FAIL new_err_wins: got %0d want 2", v[14:12]); end
    dmi_write(7'h38, 32'h0005_7000);
    dmi_write(7'h3C, 32'h9999_9999);
    respond(0, 1'b0, 32'h0);
    peek(7'h39, v);
    n_chk++; if (v !== 32'h5004) begin n_fail++; $display("FAIL write_autoinc: got %h want 5004", v); end
  endtask

  task automatic test_wait_or_timeout();
    dmi_write(7'h38, 32'h0004_0000);
    dmi_write(7'h3C, 32'h0BAD_F00D);
`ifdef DM_SBA_TIMEOUT_EN
    snap = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.bus_req) snap++;
      @(negedge clk);
    end
    n_chk++; if (snap !== 8) begin n_fail++; $display("FAIL timeout_cycles: got %0d want 8", snap); end
    peek(7'h38, v);
    n_chk++; if (v[14:12] !== 3'd1) begin n_fail++; $display("FAIL timeout_sberror: got %0d want 1", v[14:12]); end
    respond(0, 1'b0, 32'hFFFF_FFFF);
    peek(7'h3C, v);
    n_chk++; if (v !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL late_ack_ignored: got %h want 0badf00d", v); end
`else
    repeat (40) @(negedge clk);
    n_chk++; if (bus.bus_req !== 1'b1) begin n_fail++; $display("FAIL wait_forever: got %0b want 1", bus.bus_req); end
    respond(0, 1'b0, 32'h0);
    n_chk++; if (bus.bus_req !== 1'b0) begin n_fail++; $display("FAIL wait_ack_drop: got %0b want 0", bus.bus_req); end
`endif
  endtask

  task automatic test_reset_mid_access();
    dmi_write(7'h38, 32'h0004_7000);
    dmi_write(7'h3C, 32'hAAAA_AAAA);
    n_chk++; if (bus.bus_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_req_before: got %0b want 1", bus.bus_req); end
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.bus_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req_drop: got %0b want 0", bus.bus_req); end
    rst_n = 1'b1;
    peek(7'h3C, v);
    n_chk++; if (v !== 32'h0) begin n_fail++; $display("FAIL rstmid_sbdata: got %h want 0", v); end
    peek(7'h38, v);
    n_chk++; if (v !== 32'h2000_0404) begin n_fail++; $display("FAIL rstmid_sbcs: got %h want 20000404", v); end
  endtask

  initial begin
    rst_n = 1'b0; dmi_wr = 1'b0; dmi_rd = 1'b0; dmi_addr = 7'h0; dmi_wdata = 32'h0;
    bus.bus_ack = 1'b0; bus.bus_err = 1'b0; bus.bus_rdata = 32'h0;
    test_reset();
    test_write();
    test_read_on_addr();
    test_read_on_data();
    test_start_checks();
    test_busy();
    test_bus_err();
    test_wait_or_timeout();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
